// File: rtl/mem_line_master_pkg.sv
// Shared widths, state encoding and beat helpers for the memory line master.
package mem_line_master_pkg;

   localparam int unsigned MEM_ADDR_BITS  = 32;
   localparam int unsigned MEM_DATA_BITS  = 128;
   localparam int unsigned MEM_TAG_BITS   = 5;
   localparam int unsigned BEATS          = 4;
   localparam int unsigned CNT_BITS       = 2;
   localparam int unsigned LINE_ADDR_BITS = MEM_ADDR_BITS - 2;
   localparam int unsigned LINE_DATA_BITS = BEATS * MEM_DATA_BITS;
   localparam int unsigned MASK_BITS      = MEM_DATA_BITS / 8;
   localparam int unsigned LINE_MASK_BITS = BEATS * MASK_BITS;

   localparam logic [MEM_TAG_BITS-1:0] TAG       = MEM_TAG_BITS'(0);
   localparam logic [CNT_BITS-1:0]     LAST_BEAT = CNT_BITS'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_DATA = 3'd2,
      WR_SKIP = 3'd3,
      WR_REQ  = 3'd4,
      WR_DATA = 3'd5,
      DONE    = 3'd6
   } state_t;

   // Select one 128-bit beat out of a line.
   function automatic logic [MEM_DATA_BITS-1:0] beat_data(
      input logic [LINE_DATA_BITS-1:0] line,
      input logic [CNT_BITS-1:0]       idx
   );
      return line[32'(idx)*MEM_DATA_BITS +: MEM_DATA_BITS];
   endfunction

   // Select one beat's byte mask out of a line mask.
   function automatic logic [MASK_BITS-1:0] beat_mask(
      input logic [LINE_MASK_BITS-1:0] mask,
      input logic [CNT_BITS-1:0]       idx
   );
      return mask[32'(idx)*MASK_BITS +: MASK_BITS];
   endfunction

endpackage

// File: rtl/mem_line_master_beat_buf.sv
// Read-assembly buffer: four 128-bit slots, each with its own write enable.
module mem_line_beat_buf
   import mem_line_master_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [BEATS-1:0]          we,
   input  logic [MEM_DATA_BITS-1:0]  wdata,
   output logic [LINE_DATA_BITS-1:0] line
);

   // Capture an incoming beat into every enabled slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         line <= '0;
      end else begin
         for (int b = 0; b < int'(BEATS); b++) begin
            if (we[b]) line[b*MEM_DATA_BITS +: MEM_DATA_BITS] <= wdata;
         end
      end
   end

endmodule

// File: rtl/mem_line_master.sv
// Initiator that turns one 512-bit line request into memory beat transactions.
module mem_line_master
   import mem_line_master_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      line_req_valid,
   output logic                      line_req_ready,
   input  logic                      line_req_rw,
   input  logic [LINE_ADDR_BITS-1:0] line_req_addr,
   input  logic [LINE_DATA_BITS-1:0] line_req_wdata,
   input  logic [LINE_MASK_BITS-1:0] line_req_wmask,
   output logic                      line_resp_valid,
   output logic [LINE_DATA_BITS-1:0] line_resp_data,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_rw,
   output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
   output logic [MEM_TAG_BITS-1:0]   mem_req_tag,
   output logic                      mem_req_data_valid,
   input  logic                      mem_req_data_ready,
   output logic [MEM_DATA_BITS-1:0]  mem_req_data_bits,
   output logic [MASK_BITS-1:0]      mem_req_data_mask,
   input  logic                      mem_resp_valid,
   input  logic [MEM_DATA_BITS-1:0]  mem_resp_data,
   input  logic [MEM_TAG_BITS-1:0]   mem_resp_tag
);

   state_t                    state, state_n;
   logic [CNT_BITS-1:0]       cnt, cnt_n;
   logic                      accept;
   logic                      read_done;
   logic                      beat_ok;
   logic [BEATS-1:0]          slot_we;
   logic [LINE_ADDR_BITS-1:0] line_q, line_n;
   logic [LINE_DATA_BITS-1:0] wdata_q;
   logic [LINE_MASK_BITS-1:0] wmask_q;
   logic [LINE_DATA_BITS-1:0] buf_line, assembled;

   assign mem_req_tag = TAG;
   assign beat_ok     = mem_resp_valid && (mem_resp_tag == TAG);
   assign line_n      = accept ? line_req_addr : line_q;

   // Next-state, beat counter and read-slot enables.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      accept    = 1'b0;
      read_done = 1'b0;
      slot_we   = '0;
      case (state)
         IDLE: begin
            if (line_req_valid) begin
               accept  = 1'b1;
               cnt_n   = '0;
               state_n = line_req_rw ? WR_SKIP : RD_REQ;
            end
         end
         RD_REQ: begin
            if (mem_req_ready) state_n = RD_DATA;
         end
         RD_DATA: begin
            if (beat_ok) begin
               slot_we[cnt] = 1'b1;
               if (cnt == LAST_BEAT) begin
                  read_done = 1'b1;
                  state_n   = DONE;
               end else begin
                  cnt_n = cnt + CNT_BITS'(1);
               end
            end
         end
         WR_SKIP: begin
            if (beat_mask(wmask_q, cnt) == '0) begin
               if (cnt == LAST_BEAT) state_n = DONE;
               else                  cnt_n   = cnt + CNT_BITS'(1);
            end else begin
               state_n = WR_REQ;
            end
         end
         WR_REQ: begin
            if (mem_req_ready) state_n = WR_DATA;
         end
         WR_DATA: begin
            if (mem_req_data_ready) begin
               if (cnt == LAST_BEAT) begin
                  state_n = DONE;
               end else begin
                  cnt_n   = cnt + CNT_BITS'(1);
                  state_n = WR_SKIP;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Completed line: buffered slots with the beat arriving this cycle merged in.
   always_comb begin
      assembled = buf_line;
      for (int b = 0; b < int'(BEATS); b++) begin
         if (slot_we[b]) assembled[b*MEM_DATA_BITS +: MEM_DATA_BITS] = mem_resp_data;
      end
   end

   // State and beat counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Latch the client request so it may change after acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (accept) begin
         line_q  <= line_req_addr;
         wdata_q <= line_req_wdata;
         wmask_q <= line_req_wmask;
      end
   end

   // Registered outputs decoded from the upcoming state; payloads only move when entering a valid state.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_req_ready     <= 1'b1;
         line_resp_valid    <= 1'b0;
         line_resp_data     <= '0;
         mem_req_valid      <= 1'b0;
         mem_req_rw         <= 1'b0;
         mem_req_addr       <= '0;
         mem_req_data_valid <= 1'b0;
         mem_req_data_bits  <= '0;
         mem_req_data_mask  <= '0;
      end else begin
         line_req_ready     <= (state_n == IDLE);
         line_resp_valid    <= (state_n == DONE);
         mem_req_valid      <= (state_n == RD_REQ) || (state_n == WR_REQ);
         mem_req_data_valid <= (state_n == WR_DATA);
         if (state_n == RD_REQ) begin
            mem_req_rw   <= 1'b0;
            mem_req_addr <= {line_n, 2'b00};
         end else if (state_n == WR_REQ) begin
            mem_req_rw   <= 1'b1;
            mem_req_addr <= {line_q, cnt_n};
         end
         if (state_n == WR_DATA) begin
            mem_req_data_bits <= beat_data(wdata_q, cnt_n);
            mem_req_data_mask <= beat_mask(wmask_q, cnt_n);
         end
         if (read_done) line_resp_data <= assembled;
      end
   end

   mem_line_beat_buf u_beat_buf (
      .clk   (clk),
      .reset (reset),
      .we    (slot_we),
      .wdata (mem_resp_data),
      .line  (buf_line)
   );

endmodule

// File: tb/tb_mem_line_master.sv
// Directed self-checking bench for mem_line_master with a small memory model.
module tb_mem_line_master;
   import mem_line_master_pkg::*;

   localparam logic [127:0] WA = {4{32'hA1A2A3A4}};
   localparam logic [127:0] WB = {4{32'hB1B2B3B4}};
   localparam logic [127:0] WC = {4{32'hC1C2C3C4}};
   localparam logic [127:0] WD = {4{32'hD1D2D3D4}};
   localparam logic [127:0] WE = {4{32'hE1E2E3E4}};
   localparam logic [127:0] WF = {4{32'hF1F2F3F4}};
   localparam logic [127:0] WG = {4{32'h61626364}};
   localparam logic [127:0] WH = {4{32'h71727374}};

   logic          clk = 1'b0;
   logic          reset;
   logic          line_req_valid;
   logic          line_req_ready;
   logic          line_req_rw;
   logic [29:0]   line_req_addr;
   logic [511:0]  line_req_wdata;
   logic [63:0]   line_req_wmask;
   logic          line_resp_valid;
   logic [511:0]  line_resp_data;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_rw;
   logic [31:0]   mem_req_addr;
   logic [4:0]    mem_req_tag;
   logic          mem_req_data_valid;
   logic          mem_req_data_ready;
   logic [127:0]  mem_req_data_bits;
   logic [15:0]   mem_req_data_mask;
   logic          mem_resp_valid;
   logic [127:0]  mem_resp_data;
   logic [4:0]    mem_resp_tag;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int valid_cycles = 0;
   int data_fires = 0;
   logic [127:0] mem [0:255];
   logic [32:0]  req_log [$];
   logic [31:0]  last_wr_addr = '0;

   always #5 clk = ~clk;

   mem_line_master dut (
      .clk                (clk),
      .reset              (reset),
      .line_req_valid     (line_req_valid),
      .line_req_ready     (line_req_ready),
      .line_req_rw        (line_req_rw),
      .line_req_addr      (line_req_addr),
      .line_req_wdata     (line_req_wdata),
      .line_req_wmask     (line_req_wmask),
      .line_resp_valid    (line_resp_valid),
      .line_resp_data     (line_resp_data),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_rw         (mem_req_rw),
      .mem_req_addr       (mem_req_addr),
      .mem_req_tag        (mem_req_tag),
      .mem_req_data_valid (mem_req_data_valid),
      .mem_req_data_ready (mem_req_data_ready),
      .mem_req_data_bits  (mem_req_data_bits),
      .mem_req_data_mask  (mem_req_data_mask),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_data      (mem_resp_data),
      .mem_resp_tag       (mem_resp_tag)
   );

   // Cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: preload during reset, log address fires, apply masked write beats.
   always @(posedge clk) begin
      if (reset) begin
         mem[8'h40] = WA; mem[8'h41] = WB; mem[8'h42] = WC; mem[8'h43] = WD;
         mem[8'h80] = WE; mem[8'h81] = WF; mem[8'h82] = WG; mem[8'h83] = WH;
      end
      if (mem_req_valid) valid_cycles++;
      if (mem_req_valid && mem_req_ready) begin
         req_log.push_back({mem_req_rw, mem_req_addr});
         last_wr_addr = mem_req_addr;
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
         data_fires++;
         for (int k = 0; k < 16; k++)
            if (mem_req_data_mask[k]) mem[last_wr_addr[7:0]][k*8 +: 8] = mem_req_data_bits[k*8 +: 8];
      end
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic read_line(input logic [29:0] line, input int stall, input bit bad_beat,
                            output logic [511:0] data, output int lat);
      int mark;
      logic [31:0] base;
      base = {line, 2'b00};
      mark = cyc;
      line_req_valid = 1'b1; line_req_rw = 1'b0; line_req_addr = line; mem_req_ready = 1'b0;
      step();
      line_req_valid = 1'b0; line_req_addr = ~line;
      check("rd_req_valid", 512'(mem_req_valid), 512'(1));
      check("rd_req_addr", 512'(mem_req_addr), 512'(base));
      check("rd_req_rw", 512'(mem_req_rw), 512'(0));
      for (int s = 0; s < stall; s++) begin
         step();
         check("rd_stall_valid", 512'(mem_req_valid), 512'(1));
         check("rd_stall_addr", 512'(mem_req_addr), 512'(base));
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check("rd_req_drop", 512'(mem_req_valid), 512'(0));
      for (int i = 0; i < 4; i++) begin
         if (bad_beat && i == 2) begin
            mem_resp_valid = 1'b1; mem_resp_tag = 5'd3; mem_resp_data = {4{32'hDEADBEEF}};
            step();
         end
         mem_resp_valid = 1'b1; mem_resp_tag = TAG; mem_resp_data = mem[base[7:0] + 8'(i)];
         step();
      end
      mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
      for (int w = 0; w < 20 && !line_resp_valid; w++) step();
      lat = cyc - mark;
      check("rd_resp_valid", 512'(line_resp_valid), 512'(1));
      data = line_resp_data;
      step();
      check("rd_resp_pulse", 512'(line_resp_valid), 512'(0));
   endtask

   task automatic write_line(input logic [29:0] line, input logic [511:0] wdata,
                             input logic [63:0] wmask, output int lat);
      int mark;
      mark = cyc;
      line_req_valid = 1'b1; line_req_rw = 1'b1; line_req_addr = line;
      line_req_wdata = wdata; line_req_wmask = wmask;
      mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
      step();
      line_req_valid = 1'b0; line_req_addr = ~line; line_req_wdata = ~wdata; line_req_wmask = '1;
      for (int w = 0; w < 60 && !line_resp_valid; w++) step();
      lat = cyc - mark;
      check("wr_resp_valid", 512'(line_resp_valid), 512'(1));
      step();
      check("wr_resp_pulse", 512'(line_resp_valid), 512'(0));
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
   endtask

   initial begin
      logic [511:0] rdata;
      int lat;
      int n0;
      int d0;
      int v0;

      reset = 1'b1;
      line_req_valid = 1'b0; line_req_rw = 1'b0; line_req_addr = '0;
      line_req_wdata = '0; line_req_wmask = '0;
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_tag = '0;
      step();
      check("rst_ready", 512'(line_req_ready), 512'(1));
      check("rst_req_valid", 512'(mem_req_valid), 512'(0));
      check("rst_data_valid", 512'(mem_req_data_valid), 512'(0));
      check("rst_resp_valid", 512'(line_resp_valid), 512'(0));
      check("rst_resp_data", line_resp_data, 512'(0));
      check("rst_addr", 512'(mem_req_addr), 512'(0));
      check("rst_rw", 512'(mem_req_rw), 512'(0));
      check("rst_tag", 512'(mem_req_tag), 512'(0));
      reset = 1'b0;
      step();

      // Plain read of line 0x10.
      n0 = req_log.size();
      read_line(30'h10, 0, 1'b0, rdata, lat);
      check("rd1_data", rdata, {WD, WC, WB, WA});
      check("rd1_lat", 512'(lat), 512'(6));
      check("rd1_nreq", 512'(req_log.size() - n0), 512'(1));
      check("rd1_req", 512'(req_log[n0]), 512'({1'b0, 32'h40}));

      // Full-mask write, then readback.
      n0 = req_log.size(); d0 = data_fires;
      write_line(30'h10, {128'h4, 128'h3, 128'h2, 128'h1}, '1, lat);
      check("wr1_nreq", 512'(req_log.size() - n0), 512'(4));
      for (int i = 0; i < 4; i++)
         check("wr1_req", 512'(req_log[n0 + i]), 512'({1'b1, 32'h40 + 32'(i)}));
      check("wr1_ndata", 512'(data_fires - d0), 512'(4));
      check("wr1_resp_held", line_resp_data, {WD, WC, WB, WA});
      read_line(30'h10, 0, 1'b0, rdata, lat);
      check("wr1_readback", rdata, {128'h4, 128'h3, 128'h2, 128'h1});

      // Beats 1 and 3 masked off: only 0x40 and 0x42 written.
      n0 = req_log.size(); d0 = data_fires;
      write_line(30'h10, {128'h8, 128'h7, 128'h6, 128'h5},
                 {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}, lat);
      check("wr2_nreq", 512'(req_log.size() - n0), 512'(2));
      check("wr2_req0", 512'(req_log[n0]), 512'({1'b1, 32'h40}));
      check("wr2_req1", 512'(req_log[n0 + 1]), 512'({1'b1, 32'h42}));
      check("wr2_ndata", 512'(data_fires - d0), 512'(2));
      read_line(30'h10, 0, 1'b0, rdata, lat);
      check("wr2_readback", rdata, {128'h4, 128'h7, 128'h2, 128'h5});

      // All-zero mask: no memory traffic, quick completion.
      v0 = valid_cycles; d0 = data_fires;
      write_line(30'h10, {4{128'hFF}}, '0, lat);
      check("wr0_no_valid", 512'(valid_cycles - v0), 512'(0));
      check("wr0_no_data", 512'(data_fires - d0), 512'(0));
      check("wr0_lat_le5", 512'(lat <= 5), 512'(1));
      check("wr0_resp_held", line_resp_data, {128'h4, 128'h7, 128'h2, 128'h5});

      // Wrong-tag beat mid-read plus a 3-cycle request stall.
      n0 = req_log.size();
      read_line(30'h10, 3, 1'b1, rdata, lat);
      check("rdx_data", rdata, {128'h4, 128'h7, 128'h2, 128'h5});
      check("rdx_nreq", 512'(req_log.size() - n0), 512'(1));
      check("rdx_lat", 512'(lat), 512'(10));

      // Reset during RD_DATA after two beats.
      line_req_valid = 1'b1; line_req_rw = 1'b0; line_req_addr = 30'h20;
      step();
      line_req_valid = 1'b0; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_valid = 1'b1; mem_resp_tag = TAG; mem_resp_data = mem[8'h80 + 8'(i)];
         step();
      end
      mem_resp_valid = 1'b0;
      reset = 1'b1;
      step();
      check("mid_rst_req_valid", 512'(mem_req_valid), 512'(0));
      check("mid_rst_data_valid", 512'(mem_req_data_valid), 512'(0));
      check("mid_rst_resp_valid", 512'(line_resp_valid), 512'(0));
      check("mid_rst_ready", 512'(line_req_ready), 512'(1));
      check("mid_rst_resp_data", line_resp_data, 512'(0));
      reset = 1'b0;
      step();
      check("post_rst_resp_valid", 512'(line_resp_valid), 512'(0));
      check("post_rst_ready", 512'(line_req_ready), 512'(1));

      // Fresh read after reset.
      read_line(30'h20, 0, 1'b0, rdata, lat);
      check("rd2_data", rdata, {WH, WG, WF, WE});
      check("rd2_lat", 512'(lat), 512'(6));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
